// File: rtl/mcpu5_pkg.sv
// mcpu5_pkg: shared constants and types for the mcpu5 sequencer.
//   PROG_DEPTH / PROG_AW : program memory depth and address width
//   OP_OUT               : instruction whose accu value is captured for the consumer
//   OP_HALT              : instruction that halts the sequencer when MCPU5_SEQ_HALT_OP_EN is set
//   state_e / phase_e    : sequencer state and CPU clock phase encodings
package mcpu5_pkg;

  localparam int unsigned PROG_DEPTH = 64;
  localparam int unsigned PROG_AW    = $clog2(PROG_DEPTH);

  localparam logic [5:0] OP_OUT  = 6'b111001;
  localparam logic [5:0] OP_HALT = 6'b111011;

  typedef enum logic [2:0] {
    StIdle,
    StReset,
    StRun,
    StStall,
    StHalt
  } state_e;

  // PL* drive cpu_clk low, PH* drive it high; the CPU edge is the PL1 -> PH0 step.
  typedef enum logic [1:0] {
    PhPl0,
    PhPl1,
    PhPh0,
    PhPh1
  } phase_e;

endpackage

// File: rtl/mcpu5_prog_mem.sv
// mcpu5_prog_mem: 64x6 program store, synchronous write, asynchronous read.
// No reset: contents survive rst_n so a program can be reloaded or rerun.
//   clk   : write clock
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : read address
//   rdata : combinational read data
module mcpu5_prog_mem
  import mcpu5_pkg::*;
(
  input  logic               clk,
  input  logic               we,
  input  logic [PROG_AW-1:0] waddr,
  input  logic [5:0]         wdata,
  input  logic [PROG_AW-1:0] raddr,
  output logic [5:0]         rdata
);

  logic [5:0] mem_q [PROG_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/mcpu5_seq.sv
// mcpu5_seq: loads a program, then drives an external CPU through 4-phase
// CPU cycles, feeding instructions and capturing accu on OUT instructions.
// Optional feature macro: MCPU5_SEQ_HALT_OP_EN (OP_HALT stops the sequencer).
//   clk, rst_n              : system clock, synchronous active-low reset
//   load_valid/data/ready   : program word load handshake
//   start                   : reset CPU and run from pc 0 (only in IDLE/HALT)
//   halt_req                : stop at the end of the current CPU cycle
//   cpu_clk, cpu_rst        : CPU clock and active-high CPU reset
//   cpu_inst                : instruction presented to the CPU
//   cpu_out                 : pc while cpu_clk=1, accu while cpu_clk=0
//   out_valid/data/ready    : captured OUT value handshake
//   busy, halted            : status
module mcpu5_seq
  import mcpu5_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_valid,
  input  logic [5:0] load_data,
  output logic       load_ready,
  input  logic       start,
  input  logic       halt_req,
  output logic       cpu_clk,
  output logic       cpu_rst,
  output logic [5:0] cpu_inst,
  input  logic [7:0] cpu_out,
  output logic       out_valid,
  output logic [7:0] out_data,
  input  logic       out_ready,
  output logic       busy,
  output logic       halted
);

  state_e state_q, state_d;
  phase_e phase_q, phase_d;

  logic               cpu_clk_q, cpu_clk_d;
  logic               cpu_rst_q, cpu_rst_d;
  logic [5:0]         cpu_inst_q, cpu_inst_d;
  logic               out_valid_q, out_valid_d;
  logic [7:0]         out_data_q, out_data_d;
  logic [PROG_AW-1:0] wptr_q, wptr_d;
  logic [PROG_AW-1:0] pc_q, pc_d;
  logic               rst_cyc_q, rst_cyc_d;    // set once the first RESET cycle is done
  logic               halt_pend_q, halt_pend_d;

  logic       load_fire;
  logic       out_space;
  logic       capture;
  logic       halt_op;
  logic [5:0] mem_rdata;

  assign load_ready = ((state_q == StIdle) || (state_q == StHalt)) && !start;
  assign load_fire  = load_valid && load_ready;
  assign out_space  = !out_valid_q || out_ready;

`ifdef MCPU5_SEQ_HALT_OP_EN
  assign halt_op = (cpu_inst_q == OP_HALT);
`else
  assign halt_op = 1'b0;
`endif

  mcpu5_prog_mem u_mem (
    .clk   (clk),
    .we    (load_fire && rst_n),
    .waddr (wptr_q),
    .wdata (load_data),
    .raddr (pc_q),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d     = state_q;
    phase_d     = phase_q;
    cpu_rst_d   = cpu_rst_q;
    cpu_inst_d  = cpu_inst_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    wptr_d      = wptr_q;
    pc_d        = pc_q;
    rst_cyc_d   = rst_cyc_q;
    halt_pend_d = halt_pend_q;
    capture     = 1'b0;

    if (load_fire) begin
      wptr_d = wptr_q + 6'd1;
    end

    case (state_q)
      StIdle, StHalt: begin
        if (start) begin
          state_d     = StReset;
          phase_d     = PhPl0;
          wptr_d      = '0;
          pc_d        = '0;
          cpu_rst_d   = 1'b1;
          cpu_inst_d  = '0;
          rst_cyc_d   = 1'b0;
          halt_pend_d = 1'b0;
        end
      end

      StReset: begin
        unique case (phase_q)
          PhPl0: phase_d = PhPl1;
          PhPl1: phase_d = PhPh0;
          PhPh0: phase_d = PhPh1;
          PhPh1: begin
            phase_d = PhPl0;
            if (rst_cyc_q) begin
              state_d   = StRun;
              cpu_rst_d = 1'b0;
            end else begin
              rst_cyc_d = 1'b1;
            end
          end
        endcase
      end

      StRun: begin
        if (halt_req) begin
          halt_pend_d = 1'b1;
        end
        unique case (phase_q)
          PhPl0: begin
            cpu_inst_d = mem_rdata;
            phase_d    = PhPl1;
          end
          PhPl1: begin
            if (halt_op) begin
              // Replaces the CPU edge, so the halt instruction is never executed.
              state_d     = StHalt;
              phase_d     = PhPl0;
              halt_pend_d = 1'b0;
            end else if (cpu_inst_q == OP_OUT) begin
              if (out_space) begin
                capture = 1'b1;
                phase_d = PhPh0;
              end else begin
                state_d = StStall;
              end
            end else begin
              phase_d = PhPh0;
            end
          end
          PhPh0: phase_d = PhPh1;
          PhPh1: begin
            pc_d    = cpu_out[PROG_AW-1:0];
            phase_d = PhPl0;
            if (halt_req || halt_pend_q) begin
              state_d     = StHalt;
              halt_pend_d = 1'b0;
            end
          end
        endcase
      end

      StStall: begin
        if (halt_req) begin
          halt_pend_d = 1'b1;
        end
        if (out_space) begin
          capture = 1'b1;
          state_d = StRun;
          phase_d = PhPh0;
        end
      end

      default: state_d = StIdle;
    endcase

    cpu_clk_d = ((state_d == StReset) || (state_d == StRun)) &&
                ((phase_d == PhPh0) || (phase_d == PhPh1));

    if (capture) begin
      out_data_d  = cpu_out;
      out_valid_d = 1'b1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      phase_q     <= PhPl0;
      cpu_clk_q   <= 1'b0;
      cpu_rst_q   <= 1'b1;
      cpu_inst_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      wptr_q      <= '0;
      pc_q        <= '0;
      rst_cyc_q   <= 1'b0;
      halt_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      phase_q     <= phase_d;
      cpu_clk_q   <= cpu_clk_d;
      cpu_rst_q   <= cpu_rst_d;
      cpu_inst_q  <= cpu_inst_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      wptr_q      <= wptr_d;
      pc_q        <= pc_d;
      rst_cyc_q   <= rst_cyc_d;
      halt_pend_q <= halt_pend_d;
    end
  end

  assign cpu_clk   = cpu_clk_q;
  assign cpu_rst   = cpu_rst_q;
  assign cpu_inst  = cpu_inst_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign busy      = (state_q == StReset) || (state_q == StRun) || (state_q == StStall);
  assign halted    = (state_q == StHalt);

endmodule

// File: tb/tb_mcpu5_seq.sv
// Bench for mcpu5_seq. A toy CPU answers on cpu_out: 00iiii = acc += i,
// 01iiii = acc = i, 10iiii = jump to i, 11xxxx = no-op (OUT included).
// The reference model executes the loaded program word by word and
// predicts every fetch and every OUT value.
module tb_mcpu5_seq;
  import mcpu5_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       load_valid = 1'b0;
  logic [5:0] load_data = '0;
  logic       load_ready;
  logic       start = 1'b0;
  logic       halt_req = 1'b0;
  logic       cpu_clk, cpu_rst;
  logic [5:0] cpu_inst;
  logic [7:0] cpu_out;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ready = 1'b0;
  logic       busy, halted;

  always #5 clk = ~clk;

  mcpu5_seq dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .start      (start),
    .halt_req   (halt_req),
    .cpu_clk    (cpu_clk),
    .cpu_rst    (cpu_rst),
    .cpu_inst   (cpu_inst),
    .cpu_out    (cpu_out),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .busy       (busy),
    .halted     (halted)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [5:0] isa_pc(input logic [5:0] inst, input logic [5:0] pc);
    if (inst[5:4] == 2'b10) return {2'b00, inst[3:0]};
    return pc + 6'd1;
  endfunction

  function automatic logic [7:0] isa_acc(input logic [5:0] inst, input logic [7:0] acc);
    case (inst[5:4])
      2'b00:   return acc + {4'h0, inst[3:0]};
      2'b01:   return {4'h0, inst[3:0]};
      default: return acc;
    endcase
  endfunction

  // Toy CPU
  logic [5:0] tcpu_pc = '0;
  logic [7:0] tcpu_acc = '0;
  logic       cpu_clk_prev = 1'b0;
  assign cpu_out = cpu_clk ? {2'b00, tcpu_pc} : tcpu_acc;

  // Reference model
  logic [5:0] ref_mem [64];
  logic [5:0] ref_pc = '0;
  logic [5:0] ref_wptr = '0;
  logic [7:0] ref_acc = '0;
  logic [7:0] exp_q [$];
  int         edge_cnt = 0;
  int         rst_edges = 0;
  int         hs_cnt = 0;
  logic [7:0] last_hs = '0;

  always @(negedge clk) begin
    logic [5:0] w;
    if (cpu_clk && !cpu_clk_prev) begin
      if (cpu_rst) begin
        rst_edges++;
        check("rst_inst", {26'd0, cpu_inst}, 32'd0);
        tcpu_pc  = '0;
        tcpu_acc = '0;
      end else begin
        if (edge_cnt == 0) check("rst_cycles", rst_edges, 2);
        w = ref_mem[ref_pc];
        check("fetch", {26'd0, cpu_inst}, {26'd0, w});
        if (w == OP_OUT) exp_q.push_back(ref_acc);
        ref_acc  = isa_acc(w, ref_acc);
        ref_pc   = isa_pc(w, ref_pc);
        tcpu_acc = isa_acc(cpu_inst, tcpu_acc);
        tcpu_pc  = isa_pc(cpu_inst, tcpu_pc);
        edge_cnt++;
      end
    end
    cpu_clk_prev = cpu_clk;
    if (rst_n && out_valid && out_ready) begin
      hs_cnt++;
      last_hs = out_data;
      check("out_expected", {31'd0, exp_q.size() > 0}, 32'd1);
      if (exp_q.size() > 0) check("out_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic load_word(input logic [5:0] w);
    load_valid = 1'b1;
    load_data  = w;
    tick(1);
    load_valid = 1'b0;
    ref_mem[ref_wptr] = w;
    ref_wptr = ref_wptr + 6'd1;
  endtask

  function automatic logic [5:0] rand_inst();
    logic [5:0] w;
    case ($urandom_range(0, 7))
      0, 1:    w = {2'b01, 4'($urandom)};
      2, 3:    w = {2'b00, 4'($urandom)};
      4, 5:    w = OP_OUT;
      6:       w = {2'b10, 4'($urandom)};
      default: w = 6'b110000;
    endcase
    return w;
  endfunction

  task automatic do_start(input logic with_load);
    start      = 1'b1;
    load_valid = with_load;
    load_data  = 6'h3f;
    #1;
    check("ld_rdy_start", {31'd0, load_ready}, 32'd0);
    @(posedge clk);
    #1;
    start      = 1'b0;
    load_valid = 1'b0;
    ref_pc    = '0;
    ref_acc   = '0;
    ref_wptr  = '0;
    edge_cnt  = 0;
    rst_edges = 0;
  endtask

  task automatic wait_edges(input int n, input bit rnd);
    int t = 0;
    while (edge_cnt < n && t < n * 60 + 200) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      tick(1);
      t++;
    end
    check("edge_timeout", {31'd0, edge_cnt >= n}, 32'd1);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick(3);
    check("drain_q", exp_q.size(), 32'd0);
    check("drain_valid", {31'd0, out_valid}, 32'd0);
  endtask

  task automatic stop_run(input bit rnd);
    int t = 0;
    halt_req = 1'b1;
    while (!halted && t < 300) begin
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      tick(1);
      t++;
    end
    check("halt_reached", {31'd0, halted}, 32'd1);
    check("halt_cpu_clk", {31'd0, cpu_clk}, 32'd0);
    check("halt_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    check("halt_busy", {31'd0, busy}, 32'd0);
    halt_req = 1'b0;
    drain();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_cpu_rst"}, {31'd0, cpu_rst}, 32'd1);
    check({tag, "_cpu_clk"}, {31'd0, cpu_clk}, 32'd0);
    check({tag, "_cpu_inst"}, {26'd0, cpu_inst}, 32'd0);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_out_data"}, {24'd0, out_data}, 32'd0);
    check({tag, "_load_ready"}, {31'd0, load_ready}, 32'd1);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_halted"}, {31'd0, halted}, 32'd0);
  endtask

  initial begin
    int hs0;
    int e0;
    int n;
    logic c_prev;

    // Reset values
    tick(3);
    check_reset_outputs("rst");
    rst_n = 1'b1;

    // 65 words: pointer wraps and word 64 overwrites address 0
    for (int i = 0; i < 64; i++) load_word(6'(i));
    load_word(6'h15);
    check("wrap_mem0", {26'd0, dut.u_mem.mem_q[0]}, 32'h15);
    check("wrap_wptr", {26'd0, dut.wptr_q}, 32'd1);
    do_start(1'b0);
    out_ready = 1'b1;
    wait_edges(40, 1'b0);
    stop_run(1'b0);

    // Random programs with random consumer backpressure
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 64; i++) load_word(rand_inst());
      do_start(1'b0);
      wait_edges(30, 1'b1);
      // start and load are ignored while running
      start      = 1'b1;
      load_valid = 1'b1;
      #1;
      check("ld_rdy_busy", {31'd0, load_ready}, 32'd0);
      tick(1);
      start      = 1'b0;
      load_valid = 1'b0;
      check("busy_run", {31'd0, busy}, 32'd1);
      wait_edges(120, 1'b1);
      check("no_restart", rst_edges, 32'd2);
      stop_run(1'b1);
    end

    // OUT of 4, then the halt opcode; start wins over a simultaneous load
    load_word(6'h14);
    load_word(6'h39);
    load_word(6'h3b);
    do_start(1'b1);
    check("start_prio_nowrite", {26'd0, dut.u_mem.mem_q[3]}, {26'd0, ref_mem[3]});
    out_ready = 1'b1;
`ifdef MCPU5_SEQ_HALT_OP_EN
    n = 0;
    while (!halted && n < 200) begin
      tick(1);
      n++;
    end
    check("halt_op_halted", {31'd0, halted}, 32'd1);
    check("halt_op_edges", edge_cnt, 32'd2);
    check("halt_op_cpu_clk", {31'd0, cpu_clk}, 32'd0);
    check("halt_op_out", {24'd0, last_hs}, 32'h04);
    drain();
`else
    wait_edges(3, 1'b0);
    check("plain_out", {24'd0, last_hs}, 32'h04);
    stop_run(1'b0);
`endif

    // Second OUT stalls while the first is unconsumed
    load_word(6'h14);
    load_word(6'h39);
    load_word(6'h39);
    do_start(1'b0);
    out_ready = 1'b0;
    wait_edges(2, 1'b0);
    tick(20);
    check("stall_edges", edge_cnt, 32'd2);
    check("stall_cpu_clk", {31'd0, cpu_clk}, 32'd0);
    check("stall_out_valid", {31'd0, out_valid}, 32'd1);
    check("stall_out_data", {24'd0, out_data}, 32'h04);
    check("stall_busy", {31'd0, busy}, 32'd1);
    hs0 = hs_cnt;
    out_ready = 1'b1;
    wait_edges(6, 1'b0);
    check("stall_two_xfers", {31'd0, hs_cnt >= hs0 + 2}, 32'd1);
    check("stall_second", {24'd0, last_hs}, 32'h04);
    stop_run(1'b0);

    // halt_req raised at PL0: one more CPU edge, HALT right after PH1
    for (int i = 0; i < 64; i++) load_word(rand_inst());
    do_start(1'b0);
    out_ready = 1'b1;
    wait_edges(10, 1'b0);
    c_prev = cpu_clk;
    n = 0;
    while (!(!cpu_clk && c_prev) && n < 20) begin
      c_prev = cpu_clk;
      tick(1);
      n++;
    end
    halt_req = 1'b1;
    e0 = edge_cnt;
    n = 0;
    while (!halted && n < 50) begin
      tick(1);
      n++;
    end
    check("halt_latency", n, 32'd4);
    check("halt_one_edge", edge_cnt, e0 + 1);
    check("halt_req_cpu_clk", {31'd0, cpu_clk}, 32'd0);
    halt_req = 1'b0;
    drain();

    // Reset while stalled
    for (int i = 0; i < 3; i++) load_word((i == 0) ? 6'h14 : 6'h39);
    do_start(1'b0);
    out_ready = 1'b0;
    wait_edges(2, 1'b0);
    tick(8);
    check("pre_rst_stalled", {31'd0, busy && !cpu_clk && out_valid}, 32'd1);
    rst_n = 1'b0;
    tick(1);
    check_reset_outputs("mid_rst");
    exp_q.delete();
    rst_n = 1'b1;
    tick(5);
    check("post_rst_valid", {31'd0, out_valid}, 32'd0);
    check("post_rst_idle", {31'd0, busy}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/mcpu5_seq.md
MCPU5_SEQ -- requirements
Module: mcpu5_seq

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset.
REQ-002 The ports SHALL be as follows:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- load_valid  in  1  program word offered
- load_data  in  6  program word
- load_ready  out  1  program word accepted when high with load_valid
- start  in  1  pulse: reset CPU and run from pc 0
- halt_req  in  1  level: stop CPU at the next cycle boundary
- cpu_clk  out  1  CPU clock
- cpu_rst  out  1  CPU reset, active-high
- cpu_inst  out  6  CPU instruction
- cpu_out  in  8  CPU output; pc[5:0] while cpu_clk=1, accu while cpu_clk=0
- out_valid  out  1  captured OUT data pending
- out_data  out  8  captured accu value
- out_ready  in  1  consumer accepts out_data
- busy  out  1  state is RESET, RUN or STALL
- halted  out  1  state is HALT

Function
REQ-003 The block SHALL hold a 64x6 program memory and a 6-bit write pointer wptr.
REQ-004 load_ready SHALL equal (state==IDLE or state==HALT) and not start.
REQ-005 On a load handshake, the block SHALL write mem[wptr]=load_data and increment wptr; wptr SHALL wrap 63->0.
REQ-006 The states SHALL be IDLE, RESET, RUN, STALL and HALT.
REQ-007 Each CPU cycle SHALL be 4 clk phases, PL0, PL1, PH0 and PH1, with cpu_clk=0 in PL* and cpu_clk=1 in PH*. The CPU rising edge SHALL occur on entry to PH0.
REQ-008 In PL0 of RUN, cpu_inst SHALL be set to mem[pc_q]. pc_q is the cpu_out[5:0] value sampled in PH1 of the previous cycle, and is 0 after RESET.
REQ-009 When start is asserted in IDLE or HALT, the block SHALL clear wptr and pc_q, set cpu_rst=1, and enter RESET.
REQ-010 RESET SHALL run 2 full CPU cycles with cpu_rst=1 and cpu_inst=0, then set cpu_rst=0 and enter RUN at PL0.
REQ-011 If cpu_inst==6'b111001 (OUT), the block SHALL sample cpu_out in PL1 into out_data and set out_valid=1, provided out_valid==0 or out_ready==1.
REQ-012 If the OUT capture in PL1 cannot proceed, the block SHALL enter STALL: phase holds at PL1, cpu_clk stays 0 and cpu_inst is held. It SHALL capture and return to RUN/PH0 when space frees.
REQ-013 out_valid SHALL clear on out_valid and out_ready unless a new capture occurs in the same clk, in which case it stays 1 with the new data.
REQ-014 halt_req sampled in RUN or STALL SHALL take effect only after PH1 of the current CPU cycle. The block SHALL then enter HALT with cpu_clk=0 and cpu_rst=0.
REQ-015 Simultaneous start and load_valid SHALL give start priority; no write occurs.
REQ-016 start during RESET, RUN or STALL SHALL be ignored.
REQ-017 The out_valid/out_data handshake SHALL remain operational in HALT and IDLE.

Reset
REQ-018 On rst_n=0 at clk, the block SHALL reset to: state=IDLE, phase=PL0, cpu_clk=0, cpu_rst=1, cpu_inst=0, out_valid=0, out_data=0, wptr=0, pc_q=0, busy=0, halted=0.
REQ-019 Program memory SHALL NOT be reset.
REQ-020 Reset asserted mid-operation SHALL abort the operation with no further OUT capture.

Configuration
REQ-021 With MCPU5_SEQ_HALT_OP_EN defined, a fetched 6'b111011 SHALL enter HALT in place of PH0 (no CPU edge), with the same outputs as REQ-014.
REQ-022 Without MCPU5_SEQ_HALT_OP_EN, 6'b111011 SHALL be issued to the CPU unchanged as an ordinary instruction.

Structure
REQ-023 Package mcpu5_pkg SHALL hold the OP_OUT=6'b111001 and OP_HALT=6'b111011 constants, the state enum, the phase enum and the PROG_DEPTH=64 constant.
REQ-024 Sub-module mcpu5_prog_mem SHALL implement the 64x6 memory with synchronous write and asynchronous read.

Verification
REQ-025 The bench SHALL cover these directed scenarios:
- rst_n=0 for 3 clk -> cpu_rst=1, cpu_clk=0, out_valid=0, load_ready=1, busy=0.
- Load 0x14, 0x39, 0x3B; start; out_ready=1; macro defined -> out_data=0x04, out_valid pulse, then halted=1, cpu_clk=0.
- Load 0x14, 0x39, 0x39; out_ready=0 -> the first OUT is captured, the second stalls with cpu_clk=0 and no rising edge; out_ready=1 -> two transfers of 0x04, then run resumes.
- Load 65 words 0x00..0x3F then 0x15 -> mem[0]=0x15, wptr=1.
- halt_req raised at PL0 of a RUN cycle -> exactly one more cpu_clk rising edge, HALT entered after PH1.
- rst_n=0 during STALL -> next clk all outputs at reset values, out_valid=0.
